// File: rtl/sprite_dma.sv
// sprite_dma: OAM sprite DMA bus initiator; optional odd-cycle alignment via SPRITE_DMA_ODD_ALIGN_EN.
// Latency: registered outputs, 1+2*XFER_LEN ce cycles (+1 when aligned); no backpressure, holds while ce_in is low.
module sprite_dma #(
   parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
   parameter logic [15:0] DEST_ADDR    = 16'h2004,
   parameter int          XFER_LEN     = 256
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        ce_in,
   input  logic [15:0] cpumc_a_in,
   input  logic [7:0]  cpumc_din_in,
   input  logic        cpumc_r_nw_in,
   input  logic [7:0]  mem_d_in,
   output logic        active_out,
   output logic [15:0] cpumc_a_out,
   output logic [7:0]  cpumc_d_out,
   output logic        cpumc_r_nw_out
);

   typedef enum logic [2:0] {S_IDLE, S_DUMMY, S_ALIGN, S_READ, S_WRITE} state_t;

   localparam logic [8:0] LEN = 9'(XFER_LEN);

   state_t      state, state_nxt;
   logic [7:0]  page, page_nxt;
   logic [8:0]  cnt, cnt_nxt, cnt_inc;
   logic        active_nxt;
   logic [15:0] a_nxt;
   logic        r_nw_nxt;
   logic        load_pend;
   logic        align_go;

`ifdef SPRITE_DMA_ODD_ALIGN_EN
   logic parity;

   always_ff @(posedge clk_in) begin
      if (!rst_n_in)
         parity <= 1'b0;
      else if (ce_in)
         parity <= ~parity;
   end

   assign align_go = parity;
`else
   assign align_go = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      page_nxt   = page;
      cnt_nxt    = cnt;
      active_nxt = active_out;
      a_nxt      = cpumc_a_out;
      r_nw_nxt   = cpumc_r_nw_out;
      cnt_inc    = cnt + 9'd1;
      case (state)
         S_IDLE: begin
            if (!cpumc_r_nw_in && cpumc_a_in == TRIGGER_ADDR) begin
               state_nxt  = S_DUMMY;
               page_nxt   = cpumc_din_in;
               cnt_nxt    = 9'd0;
               active_nxt = 1'b1;
               a_nxt      = 16'h0000;
               r_nw_nxt   = 1'b1;
            end
         end
         S_DUMMY: begin
            r_nw_nxt = 1'b1;
            if (align_go) begin
               state_nxt = S_ALIGN;
               a_nxt     = 16'h0000;
            end else begin
               state_nxt = S_READ;
               a_nxt     = {page, cnt[7:0]};
            end
         end
         S_ALIGN: begin
            state_nxt = S_READ;
            a_nxt     = {page, cnt[7:0]};
            r_nw_nxt  = 1'b1;
         end
         S_READ: begin
            state_nxt = S_WRITE;
            a_nxt     = DEST_ADDR;
            r_nw_nxt  = 1'b0;
         end
         S_WRITE: begin
            cnt_nxt  = cnt_inc;
            r_nw_nxt = 1'b1;
            if (cnt_inc == LEN) begin
               state_nxt  = S_IDLE;
               active_nxt = 1'b0;
               a_nxt      = 16'h0000;
            end else begin
               state_nxt = S_READ;
               a_nxt     = {page, cnt_inc[7:0]};
            end
         end
         default: begin
            state_nxt  = S_IDLE;
            active_nxt = 1'b0;
            a_nxt      = 16'h0000;
            r_nw_nxt   = 1'b1;
         end
      endcase
   end

   // Read data arrives one clk after the read cycle ends, so it is captured
   // on the first (non-ce) clk of the write phase and held until the next ce.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state          <= S_IDLE;
         page           <= 8'h00;
         cnt            <= 9'd0;
         active_out     <= 1'b0;
         cpumc_a_out    <= 16'h0000;
         cpumc_d_out    <= 8'h00;
         cpumc_r_nw_out <= 1'b1;
         load_pend      <= 1'b0;
      end else if (ce_in) begin
         state          <= state_nxt;
         page           <= page_nxt;
         cnt            <= cnt_nxt;
         active_out     <= active_nxt;
         cpumc_a_out    <= a_nxt;
         cpumc_r_nw_out <= r_nw_nxt;
         load_pend      <= (state == S_READ);
         if (state_nxt == S_IDLE)
            cpumc_d_out <= 8'h00;
      end else if (load_pend) begin
         cpumc_d_out <= mem_d_in;
         load_pend   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sprite_dma.sv
// tb_sprite_dma: directed vectors for sprite_dma (default length and XFER_LEN=1 instances)
// with behavioural RAM responders and a bus-cycle recorder on each ce pulse.
module tb_sprite_dma;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   typedef struct {
      logic [7:0] page;
      int         skip;
      bit         retrig;
      int         exp_len;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ce = 1'b0;
   bit          ce_en = 1'b1;

   logic [15:0] cpu_a = 16'h0000, cpu2_a = 16'h0000;
   logic [7:0]  cpu_d = 8'h00, cpu2_d = 8'h00;
   logic        cpu_rnw = 1'b1, cpu2_rnw = 1'b1;
   logic [7:0]  mem_d1 = 8'h00, mem_d2 = 8'h00;

   logic        act1, act2, rnw1, rnw2;
   logic [15:0] a1, a2;
   logic [7:0]  d1, d2;

   int tests = 0;
   int fails = 0;
   int ce_cnt = 0;
   int tick = 0;
   int nact1 = 0, nact2 = 0;
   bit par = 1'b0;
   bit first_par = 1'b0;
   wr_t wr1[$], wr2[$];
   logic [15:0] rd1[$], rd2[$];

   sprite_dma dut (
      .clk_in(clk), .rst_n_in(rst_n), .ce_in(ce),
      .cpumc_a_in(cpu_a), .cpumc_din_in(cpu_d), .cpumc_r_nw_in(cpu_rnw),
      .mem_d_in(mem_d1), .active_out(act1), .cpumc_a_out(a1),
      .cpumc_d_out(d1), .cpumc_r_nw_out(rnw1)
   );

   sprite_dma #(.XFER_LEN(1)) dut_short (
      .clk_in(clk), .rst_n_in(rst_n), .ce_in(ce),
      .cpumc_a_in(cpu2_a), .cpumc_din_in(cpu2_d), .cpumc_r_nw_in(cpu2_rnw),
      .mem_d_in(mem_d2), .active_out(act2), .cpumc_a_out(a2),
      .cpumc_d_out(d2), .cpumc_r_nw_out(rnw2)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ram1(input logic [15:0] a);
      return a[7:0] ^ 8'h5A ^ (a[15:8] ^ 8'h03);
   endfunction

   function automatic logic [7:0] ram2(input logic [15:0] a);
      return a[7:0] + 8'hC3;
   endfunction

   // Responders: sample the muxed bus on the ce edge, data valid one clk later.
   always @(posedge clk) begin
      if (ce && (act1 ? rnw1 : cpu_rnw))
         mem_d1 <= ram1(act1 ? a1 : cpu_a);
      if (ce && (act2 ? rnw2 : cpu2_rnw))
         mem_d2 <= ram2(act2 ? a2 : cpu2_a);
   end

   // ce generator and bus-cycle recorder (one ce every 4 clks).
   initial begin
      forever begin
         @(negedge clk);
         tick++;
         if (!rst_n) par = 1'b0;
         if (ce_en && tick % 4 == 0) begin
            ce = 1'b1;
            ce_cnt++;
            if (rst_n) begin
               if (act1) begin
                  nact1++;
                  if (nact1 == 1) first_par = par;
                  if (!rnw1) wr1.push_back('{a: a1, d: d1});
                  else rd1.push_back(a1);
               end
               if (act2) begin
                  nact2++;
                  if (!rnw2) wr2.push_back('{a: a2, d: d2});
                  else rd2.push_back(a2);
               end
               par = ~par;
            end
         end else begin
            ce = 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ce();
      int old;
      old = ce_cnt;
      wait (ce_cnt != old);
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_cycle(input int sel, input logic [15:0] a, input logic [7:0] d, input logic rnw);
      if (sel == 0) begin cpu_a = a; cpu_d = d; cpu_rnw = rnw; end
      else begin cpu2_a = a; cpu2_d = d; cpu2_rnw = rnw; end
      wait_ce();
      if (sel == 0) begin cpu_a = 16'h0000; cpu_d = 8'h00; cpu_rnw = 1'b1; end
      else begin cpu2_a = 16'h0000; cpu2_d = 8'h00; cpu2_rnw = 1'b1; end
   endtask

   task automatic clear_rec();
      wr1.delete(); rd1.delete(); wr2.delete(); rd2.delete();
      nact1 = 0; nact2 = 0;
   endtask

   task automatic wait_idle(input int sel, input string name);
      int k;
      for (k = 0; k < 4000; k++) begin
         @(negedge clk);
         if (!(sel == 0 ? act1 : act2)) break;
      end
      chk({name, "_done"}, (k < 4000) ? 1 : 0, 1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int exp_len, align;
      string nm;
      nm = $sformatf("v%0d", idx);
      clear_rec();
      repeat (v.skip) wait_ce();
      cpu_cycle(0, 16'h4014, v.page, 1'b0);
      if (v.retrig) begin
         for (int k = 0; k < 4000 && wr1.size() < 100; k++) @(negedge clk);
         chk({nm, "_reach100"}, (wr1.size() >= 100) ? 1 : 0, 1);
         cpu_cycle(0, 16'h4014, 8'h07, 1'b0);
      end
      wait_idle(0, nm);
      exp_len = v.exp_len;
`ifdef SPRITE_DMA_ODD_ALIGN_EN
      exp_len += int'(first_par);
`endif
      align = exp_len - 513;
      chk({nm, "_len"}, nact1, exp_len);
      chk({nm, "_nwr"}, wr1.size(), 256);
      chk({nm, "_nrd"}, rd1.size(), 257 + align);
      for (int i = 0; i < 256; i++) begin
         if (i < wr1.size()) begin
            chk($sformatf("%s_wa%0d", nm, i), wr1[i].a, 16'h2004);
            chk($sformatf("%s_wd%0d", nm, i), wr1[i].d, ram1({v.page, 8'(i)}));
         end
         if (1 + align + i < rd1.size())
            chk($sformatf("%s_ra%0d", nm, i), rd1[1 + align + i], {v.page, 8'(i)});
      end
      chk({nm, "_idle_a"}, a1, 16'h0000);
      chk({nm, "_idle_rnw"}, rnw1, 1);
   endtask

   vec_t vecs[3];

   initial begin
      vecs[0] = '{page: 8'h03, skip: 0, retrig: 1'b0, exp_len: 513};
      vecs[1] = '{page: 8'h03, skip: 1, retrig: 1'b1, exp_len: 513};
      vecs[2] = '{page: 8'h05, skip: 2, retrig: 1'b0, exp_len: 513};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_active", act1, 0);
      chk("rst_a", a1, 16'h0000);
      chk("rst_d", d1, 8'h00);
      chk("rst_rnw", rnw1, 1);
      chk("rst_short_active", act2, 0);
      rst_n = 1'b1;
      repeat (4) wait_ce();

      cpu_cycle(0, 16'h4014, 8'h03, 1'b1);
      repeat (2) wait_ce();
      chk("read_no_trigger", act1, 0);

      for (int i = 0; i < 3; i++) run_vec(vecs[i], i);

      // Reset mid-transfer, then a fresh transfer must start from offset 00.
      clear_rec();
      cpu_cycle(0, 16'h4014, 8'h03, 1'b0);
      for (int k = 0; k < 4000 && wr1.size() < 11; k++) @(negedge clk);
      chk("mid_reach11", (wr1.size() >= 11) ? 1 : 0, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_active", act1, 0);
      chk("mid_rst_a", a1, 16'h0000);
      chk("mid_rst_d", d1, 8'h00);
      chk("mid_rst_rnw", rnw1, 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) wait_ce();
      run_vec(vecs[0], 3);

      // XFER_LEN = 1 instance; ce withheld for a while right after the trigger.
      clear_rec();
      cpu_cycle(1, 16'h4014, 8'h00, 1'b0);
      ce_en = 1'b0;
      repeat (20) @(negedge clk);
      chk("hold_active", act2, 1);
      chk("hold_a", a2, 16'h0000);
      chk("hold_rnw", rnw2, 1);
      chk("hold_nact", nact2, 0);
      ce_en = 1'b1;
      wait_idle(1, "short");
      chk("short_len", nact2, 3);
      chk("short_nwr", wr2.size(), 1);
      chk("short_nrd", rd2.size(), 2);
      if (wr2.size() > 0) begin
         chk("short_wa", wr2[0].a, 16'h2004);
         chk("short_wd", wr2[0].d, 8'hC3);
      end
      if (rd2.size() > 1) chk("short_ra", rd2[1], 16'h0000);
      chk("short_main_idle", act1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
